wb_interconnect: RTL
====================

Name: wb_interconnect

Overview:
- Parametrised successor to the one-hot master/slave bus mux: one master, NUM_SLAVES slaves.
- Replaces the externally supplied one-hot select with internal base/mask address decoding.
- Registers each transaction through a small FSM and reports errors for unmapped addresses and, optionally, slave timeouts.
- Sits between the CPU memory stage and the peripherals (RAM, ROM, UART, GPIO, timer, ...).

Parameters:
- NUM_SLAVES, 8, number of slave ports (1..16).
- DATA_W, 32, data width; a multiple of 8.
- ADDR_W, 32, address width.
- SLAVE_BASE, {NUM_SLAVES{32'h0}}, packed NUM_SLAVES*ADDR_W base addresses; slave i is slice i.
- SLAVE_MASK, {NUM_SLAVES{32'h0}}, packed NUM_SLAVES*ADDR_W masks; slave i hits when (addr & mask_i) == base_i.
- TIMEOUT_CYCLES, 255, ack wait limit; used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic acts on the rising edge.
- rst  in  1  synchronous, active-low reset.
- m_stb_i  in  1  master request strobe; held until m_ack_o or m_err_o.
- m_we_i  in  1  1 = write, 0 = read.
- m_addr_i  in  ADDR_W  request address.
- m_data_i  in  DATA_W  write data.
- m_sel_i  in  DATA_W/8  byte enables.
- m_data_o  out  DATA_W  read data; valid when m_ack_o = 1.
- m_ack_o  out  1  one-cycle completion pulse.
- m_err_o  out  1  one-cycle error pulse: unmapped address or timeout.
- s_stb_o  out  NUM_SLAVES  per-slave strobe; at most one bit high.
- s_we_o  out  1  registered we, shared by all slaves.
- s_addr_o  out  ADDR_W  registered address, shared.
- s_data_o  out  DATA_W  registered write data, shared.
- s_sel_o  out  DATA_W/8  registered byte enables, shared.
- s_data_i  in  NUM_SLAVES*DATA_W  packed slave read data; slave i is slice i.
- s_ack_i  in  NUM_SLAVES  per-slave ack.

Behaviour:
- Reset (rst = 0 at a rising edge):
  - state returns to IDLE from any state, aborting any transaction in flight;
  - s_stb_o, m_ack_o, m_err_o, m_data_o and all registered s_* outputs go to 0 on that edge.
- FSM states: IDLE, BUSY, RESP, ERR.
- IDLE:
  - m_stb_i = 0: stay in IDLE.
  - m_stb_i = 1 and a hit: the decoder picks the lowest-index matching slave. Latch addr, data, we and sel onto the s_* outputs and set s_stb_o[idx]. Go to BUSY.
  - m_stb_i = 1 and no slave matches: go to ERR.
- BUSY:
  - s_stb_o[idx] is held.
  - On s_ack_i[idx] = 1: deassert s_stb_o. Load m_data_o with slice idx of s_data_i on a read, or with 0 on a write. Go to RESP.
  - s_ack_i bits from non-selected slaves are ignored.
- RESP: m_ack_o = 1 for exactly this cycle, then go to IDLE.
- ERR: m_err_o = 1 and m_data_o = 0 for exactly this cycle, then go to IDLE.
- Latency:
  - request sampled at edge T;
  - s_stb_o high from T+1;
  - slave ack sampled at edge T+1+k gives m_ack_o high during cycle T+2+k;
  - minimum 3 cycles from request to response.
- Back-to-back: IDLE samples m_stb_i again on the edge after RESP or ERR. A master that keeps m_stb_i high issues a new transaction; no combinational path from m_stb_i to m_ack_o.
- Overlapping windows: lowest index wins. Masks of 0 with base 0 match every address.
- m_ack_o and m_err_o are never high in the same cycle.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - an 8..16-bit wait counter clears on entry to BUSY and increments each BUSY cycle without ack;
  - when the counter reaches TIMEOUT_CYCLES with no ack, s_stb_o drops and the FSM goes to ERR;
  - if ack and timeout fall in the same cycle, ack wins.
- Undefined: no counter; BUSY waits indefinitely.

Decomposition:
- Shared defines file gains:
  - WB_ state encodings (IDLE = 2'b00, BUSY = 2'b01, RESP = 2'b10, ERR = 2'b11);
  - WB_ default data and address widths;
  - the timeout counter width.
- Sub-module wb_addr_decoder:
  - combinational; parameters NUM_SLAVES, ADDR_W, SLAVE_BASE, SLAVE_MASK;
  - outputs hit, a one-hot match vector and an index of $clog2(NUM_SLAVES) bits;
  - lowest-index priority.

Test Plan:
- Reset: hold rst = 0 for 3 cycles mid-BUSY -> s_stb_o = 0, m_ack_o = 0, m_err_o = 0, m_data_o = 0; the next request behaves as if fresh.
- Read: slave 2 at base 0x2000_0000, mask 0xF000_0000; read 0x2000_0010, slave acks after 2 cycles with 0xDEADBEEF -> s_stb_o = 8'h04; m_ack_o pulses once, 5 cycles after the request edge, with m_data_o = 0xDEADBEEF.
- Write: write 0x1234_5678 with sel 4'b0011 to slave 0 -> s_data_o = 0x12345678 and s_sel_o = 4'b0011 while s_stb_o = 8'h01; m_ack_o pulse with m_data_o = 0.
- Unmapped: access 0xF000_0000 with no window matching -> no s_stb_o bit set; m_err_o pulses 2 cycles after the request edge.
- Stray ack: s_ack_i[5] pulses while slave 1 is selected -> ignored; completes only on s_ack_i[1].
- Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES = 4): slave never acks -> s_stb_o drops; m_err_o pulses once after 4 BUSY cycles. Repeated without the macro -> stays in BUSY for 100 cycles, no m_err_o.

Source files
------------

// File: rtl/wb_interconnect_pkg.sv
// ============================================================================
//  Module   : wb_interconnect_pkg
//  Purpose  : Shared state encodings, default widths and helpers for the
//             single-master Wishbone-style interconnect.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_interconnect_pkg;

    typedef enum logic [1:0] {
        WB_IDLE = 2'b00,
        WB_BUSY = 2'b01,
        WB_RESP = 2'b10,
        WB_ERR  = 2'b11
    } wb_state_e;

    localparam int WB_DATA_W    = 32;
    localparam int WB_ADDR_W    = 32;
    localparam int WB_TMO_CNT_W = 16;

    // Index width that stays legal for a single-slave configuration.
    function automatic int wb_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_addr_decoder.sv
// ============================================================================
//  Module   : wb_addr_decoder
//  Purpose  : Combinational base/mask address decoder, lowest index wins.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_addr_decoder
    import wb_interconnect_pkg::*;
#(
    parameter int                           NUM_SLAVES = 8,
    parameter int                           ADDR_W     = WB_ADDR_W,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0,
    localparam int                          IDX_W      = wb_idx_width(NUM_SLAVES)
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic                  hit,
    output logic [NUM_SLAVES-1:0] match,
    output logic [IDX_W-1:0]      idx
);

    logic [NUM_SLAVES-1:0] raw_match;

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_window
        assign raw_match[i] =
            (addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W];
    end

    always_comb begin
        hit   = 1'b0;
        match = '0;
        idx   = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (raw_match[i] && !hit) begin
                hit      = 1'b1;
                match[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_interconnect.sv
// ============================================================================
//  Module   : wb_interconnect
//  Purpose  : One master to NUM_SLAVES slaves, registered through a 4-state
//             FSM. Define BUS_TIMEOUT_EN to enable the slave ack watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_interconnect
    import wb_interconnect_pkg::*;
#(
    parameter int                           NUM_SLAVES     = 8,
    parameter int                           DATA_W         = WB_DATA_W,
    parameter int                           ADDR_W         = WB_ADDR_W,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE     = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK     = '0,
    parameter int                           TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m_stb_i,
    input  logic                         m_we_i,
    input  logic [ADDR_W-1:0]            m_addr_i,
    input  logic [DATA_W-1:0]            m_data_i,
    input  logic [DATA_W/8-1:0]          m_sel_i,
    output logic [DATA_W-1:0]            m_data_o,
    output logic                         m_ack_o,
    output logic                         m_err_o,
    output logic [NUM_SLAVES-1:0]        s_stb_o,
    output logic                         s_we_o,
    output logic [ADDR_W-1:0]            s_addr_o,
    output logic [DATA_W-1:0]            s_data_o,
    output logic [DATA_W/8-1:0]          s_sel_o,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_data_i,
    input  logic [NUM_SLAVES-1:0]        s_ack_i
);

    localparam int IDX_W = wb_idx_width(NUM_SLAVES);

    wb_state_e             state_q, state_d;
    logic [NUM_SLAVES-1:0] s_stb_q, s_stb_d;
    logic                  s_we_q, s_we_d;
    logic [ADDR_W-1:0]     s_addr_q, s_addr_d;
    logic [DATA_W-1:0]     s_data_q, s_data_d;
    logic [DATA_W/8-1:0]   s_sel_q, s_sel_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]     m_data_q, m_data_d;

    logic                  dec_hit;
    logic [NUM_SLAVES-1:0] dec_match;
    logic [IDX_W-1:0]      dec_idx;

`ifdef BUS_TIMEOUT_EN
    localparam logic [WB_TMO_CNT_W-1:0] TMO_LAST = WB_TMO_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [WB_TMO_CNT_W-1:0] cnt_q, cnt_d;
`else
    // The limit is accepted for interface compatibility but has no effect here.
    if (TIMEOUT_CYCLES < 0) begin : g_no_timeout
    end
`endif

    wb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_dec (
        .addr  (m_addr_i),
        .hit   (dec_hit),
        .match (dec_match),
        .idx   (dec_idx)
    );

    always_comb begin
        state_d  = state_q;
        s_stb_d  = s_stb_q;
        s_we_d   = s_we_q;
        s_addr_d = s_addr_q;
        s_data_d = s_data_q;
        s_sel_d  = s_sel_q;
        idx_d    = idx_q;
        // Read data is only non-zero during the RESP cycle.
        m_data_d = '0;
`ifdef BUS_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            WB_IDLE: begin
                if (m_stb_i) begin
                    if (dec_hit) begin
                        s_stb_d  = dec_match;
                        s_we_d   = m_we_i;
                        s_addr_d = m_addr_i;
                        s_data_d = m_data_i;
                        s_sel_d  = m_sel_i;
                        idx_d    = dec_idx;
                        state_d  = WB_BUSY;
`ifdef BUS_TIMEOUT_EN
                        cnt_d    = '0;
`endif
                    end else begin
                        state_d = WB_ERR;
                    end
                end
            end
            WB_BUSY: begin
                if (s_ack_i[idx_q]) begin
                    s_stb_d  = '0;
                    m_data_d = s_we_q ? '0 : s_data_i[int'(idx_q)*DATA_W +: DATA_W];
                    state_d  = WB_RESP;
                end
`ifdef BUS_TIMEOUT_EN
                else if (cnt_q == TMO_LAST) begin
                    s_stb_d = '0;
                    state_d = WB_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            WB_RESP: state_d = WB_IDLE;
            WB_ERR:  state_d = WB_IDLE;
            default: state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= WB_IDLE;
            s_stb_q  <= '0;
            s_we_q   <= 1'b0;
            s_addr_q <= '0;
            s_data_q <= '0;
            s_sel_q  <= '0;
            idx_q    <= '0;
            m_data_q <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            s_stb_q  <= s_stb_d;
            s_we_q   <= s_we_d;
            s_addr_q <= s_addr_d;
            s_data_q <= s_data_d;
            s_sel_q  <= s_sel_d;
            idx_q    <= idx_d;
            m_data_q <= m_data_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign m_ack_o  = (state_q == WB_RESP);
    assign m_err_o  = (state_q == WB_ERR);
    assign m_data_o = m_data_q;
    assign s_stb_o  = s_stb_q;
    assign s_we_o   = s_we_q;
    assign s_addr_o = s_addr_q;
    assign s_data_o = s_data_q;
    assign s_sel_o  = s_sel_q;

endmodule

`default_nettype wire
